// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe
//   N-to-1 word selector feeding a two-entry skid buffer with valid/ready
//   handshakes on both sides. The select is resolved when a word is
//   accepted, so the buffer stores the chosen word and the select that
//   was actually used.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NUM_IN packed words; input i is in_data[i*WIDTH +: WIDTH]
//   sel        input select, sampled together with in_data
//   in_valid   upstream offers in_data/sel
//   in_ready   registered; high whenever the buffer is not full
//   out_data   oldest buffered word
//   out_sel    effective (clamped) select of that word
//   out_valid  buffer holds at least one word
//   out_ready  downstream accepts out_data this cycle
//   sel_err    sticky: an out-of-range select was accepted
//   clr_err    synchronous clear of sel_err (an error on the same edge wins)
//   xfer_cnt   wrapping count of completed output transfers
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH*NUM_IN-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clr_err,
  output logic [15:0]             xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [WIDTH-1:0]    head_data_q, head_data_d;
  logic [SEL_W-1:0]    head_sel_q, head_sel_d;
  logic [WIDTH-1:0]    tail_data_q, tail_data_d;
  logic [SEL_W-1:0]    tail_sel_q, tail_sel_d;
  logic                sel_err_q, sel_err_d;
  logic [15:0]         xfer_cnt_q, xfer_cnt_d;

  logic [WIDTH-1:0]    words [NUM_IN];
  logic                sel_oor;
  logic [SEL_W-1:0]    eff_sel;
  logic [WIDTH-1:0]    sel_word;
  logic                accept;
  logic                xfer;

  // Unpack the flat input bus into one word per input.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign words[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects (possible when NUM_IN is not a power of two)
  // are clamped to the last input.
  assign sel_oor = (sel > LAST_SEL);
  assign eff_sel = sel_oor ? LAST_SEL : sel;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (eff_sel == SEL_W'(i)) begin
        sel_word = words[i];
      end
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_data_d = sel_word;
          head_sel_d  = eff_sel;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          // Head leaves and the new word replaces it: no bubble.
          head_data_d = sel_word;
          head_sel_d  = eff_sel;
        end else if (accept) begin
          state_d     = FULL;
          tail_data_d = sel_word;
          tail_sel_d  = eff_sel;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a transfer can happen.
        if (xfer) begin
          state_d     = ONE;
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Registered ready derived from the next state keeps out_ready off any
    // combinational path to in_ready.
    in_ready_d = (state_d != FULL);

    sel_err_d = sel_err_q;
    if (accept && sel_oor) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end

    xfer_cnt_d = xfer ? (xfer_cnt_q + 16'd1) : xfer_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      sel_err_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      sel_err_q   <= sel_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = head_data_q;
  assign out_sel  = head_sel_q;
  assign sel_err  = sel_err_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
module tb_mux_nto1_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] w [3];
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;
  logic        clr_err;
  logic [15:0] xfer_cnt;

  assign in_data = {w[2], w[1], w[0]};

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .clr_err   (clr_err),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] w0, w1, w2;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
    logic        exp_err;
  } vec_t;

  exp_t        sbq [$];
  vec_t        vecs [5];
  int          checks = 0;
  int          errors = 0;
  int          n_xfer = 0;
  logic        m_rdy = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: predict handshakes from the reference model, advance the
  // edge, then compare every observable output against the model.
  task automatic step();
    logic acc, xf;
    exp_t e;
    acc = in_valid && m_rdy;
    xf  = out_ready && (sbq.size() != 0);
    if (xf) begin
      void'(sbq.pop_front());
      m_cnt++;
      n_xfer++;
    end
    if (acc) begin
      e.sel  = (sel > 2'd2) ? 2'd2 : sel;
      e.data = w[e.sel];
      sbq.push_back(e);
    end
    if (acc && sel > 2'd2) m_err = 1'b1;
    else if (clr_err)      m_err = 1'b0;
    @(posedge clk);
    #1;
    m_rdy = (sbq.size() < 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("sel_err", {31'd0, sel_err}, {31'd0, m_err});
    chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    if (sbq.size() != 0) begin
      chk("out_data", out_data, sbq[0].data);
      chk("out_sel", {30'd0, out_sel}, {30'd0, sbq[0].sel});
    end
    $display("cyc acc=%0b xfer=%0b out_valid=%0b out_data=%h out_sel=%0d in_ready=%0b sel_err=%0b cnt=%0d",
             acc, xf, out_valid, out_data, out_sel, in_ready, sel_err, xfer_cnt);
  endtask

  task automatic model_reset();
    sbq.delete();
    m_rdy  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 16'd0;
    n_xfer = 0;
  endtask

  initial begin
    vecs[0] = '{sel:2'd0, w0:32'hA5A5_0001, w1:32'h5A5A_0002, w2:32'hDEAD_0003,
                exp_data:32'hA5A5_0001, exp_sel:2'd0, exp_err:1'b0};
    vecs[1] = '{sel:2'd1, w0:32'h0000_0000, w1:32'hFFFF_FFFF, w2:32'h1234_5678,
                exp_data:32'hFFFF_FFFF, exp_sel:2'd1, exp_err:1'b0};
    vecs[2] = '{sel:2'd2, w0:32'hCAFE_0000, w1:32'hBEEF_0000, w2:32'h8000_0001,
                exp_data:32'h8000_0001, exp_sel:2'd2, exp_err:1'b0};
    vecs[3] = '{sel:2'd3, w0:32'h0101_0101, w1:32'h0202_0202, w2:32'h0303_0303,
                exp_data:32'h0303_0303, exp_sel:2'd2, exp_err:1'b1};
    vecs[4] = '{sel:2'd0, w0:32'h7777_7777, w1:32'h8888_8888, w2:32'h9999_9999,
                exp_data:32'h7777_7777, exp_sel:2'd0, exp_err:1'b0};

    rst_n = 1'b1; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("release_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();  // in_ready rises on the first edge after release

    // Basic select of input 1 with immediate transfer.
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("basic_out_data", out_data, 32'h2222_2222);
    chk("basic_out_sel", {30'd0, out_sel}, 32'd1);
    step();
    chk("basic_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);

    // Table of single accepts; each held one cycle, then drained with a clear pulse.
    for (int i = 0; i < 5; i++) begin
      w[0] = vecs[i].w0; w[1] = vecs[i].w1; w[2] = vecs[i].w2;
      sel = vecs[i].sel; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("vec_out_data", out_data, vecs[i].exp_data);
      chk("vec_out_sel", {30'd0, out_sel}, {30'd0, vecs[i].exp_sel});
      chk("vec_sel_err", {31'd0, sel_err}, {31'd0, vecs[i].exp_err});
      out_ready = 1'b1; clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("vec_err_cleared", {31'd0, sel_err}, 32'd0);
    end

    // Back-pressure: three offers against a stalled output.
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd0; step();
    sel = 2'd1; step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    sel = 2'd2; step();
    step();
    chk("stall_head", out_data, 32'h1111_1111);
    out_ready = 1'b1;
    step();
    chk("drain_second", out_data, 32'h2222_2222);
    step();
    in_valid = 1'b0;
    chk("third_accepted", out_data, 32'h3333_3333);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Clear and out-of-range accept on the same edge: set wins.
    sel = 2'd3; in_valid = 1'b1; clr_err = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; clr_err = 1'b0;
    chk("set_wins", {31'd0, sel_err}, 32'd1);
    out_ready = 1'b1; clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Asynchronous reset while FULL.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    step(); step();
    in_valid = 1'b0;
    chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Streaming: one transfer per cycle, counter wraps past 0xFFFF.
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_xfer < 70000) begin
      w[0] = $urandom; w[1] = $urandom; w[2] = $urandom;
      sel = 2'($urandom_range(0, 3));
      clr_err = ($urandom_range(0, 7) == 0);
      step();
    end
    chk("wrap_cnt", {16'd0, xfer_cnt}, 32'h0000_1170);
    in_valid = 1'b0; clr_err = 1'b0;
    step(); step();
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
